// File: rtl/ether_pkg.sv
// Shared types and constants for the RMII receive-to-bus bridge.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Contents: FSM state enum, RMII framing dibits, header size, broadcast MAC.
package ether_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PREAMBLE,
      HEADER,
      COUNT,
      RECORD,
      DRAIN
   } state_t;

   // 0x55 preamble bytes arrive as a run of 01 dibits; the SFD (0xD5)
   // is told apart from them only by its final 11 dibit.
   localparam logic [1:0]  PREAMBLE_DIBIT = 2'b01;
   localparam logic [1:0]  SFD_DIBIT      = 2'b11;

   // dst MAC + src MAC + ethertype.
   localparam int          HEADER_BYTES   = 14;
   localparam int          DST_BYTES      = 6;

   localparam logic [47:0] BCAST_MAC      = 48'hFFFF_FFFF_FFFF;

endpackage

// File: rtl/rmii_dibit_deser.sv
// Packs RMII dibits (LSB first) into bytes, flagging each completed byte.
// Latency: combinational; the byte is presented with its 4th dibit.
// Backpressure: none; i_en gates shifting, i_clr realigns on the SFD.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_en            shift in i_rxd this cycle
//   i_clr           restart byte alignment (SFD seen)
//   i_rxd           RMII receive dibit
//   o_byte_vld      one-cycle flag: o_byte_dat is a complete byte
//   o_byte_dat      assembled byte
module rmii_dibit_deser (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_en,
   input  logic       i_clr,
   input  logic [1:0] i_rxd,
   output logic       o_byte_vld,
   output logic [7:0] o_byte_dat
);

   logic [1:0] r_cnt;
   // Holds the first three dibits of the current byte; the oldest dibit
   // sits in the low bits, so the fourth dibit completes the byte directly.
   logic [5:0] r_sh;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_cnt <= 2'd0;
         r_sh  <= 6'd0;
      end else if (i_en) begin
         r_cnt <= r_cnt + 2'd1;
         r_sh  <= {i_rxd, r_sh[5:2]};
      end
   end

   assign o_byte_vld = i_en && (r_cnt == 2'd3);
   assign o_byte_dat = {i_rxd, r_sh};

endmodule

// File: rtl/ether_bus_rx.sv
// Decodes RMII frames (preamble/SFD, dst MAC, ethertype, count, records)
// into bus transactions. Latency: valid_o 1 cycle after the last dibit.
// Backpressure: none; the core bus always accepts.
//
// Ports:
//   clk, rst        50 MHz RMII clock, synchronous active-high reset
//   crsdv, rxd      RMII carrier-sense/data-valid and receive dibit
//   addr_o, data_o  transaction address / write data (held between strobes)
//   rw_o            1 = write, 0 = read
//   valid_o         one-cycle transaction strobe
//   drop_o          one-cycle strobe when a frame is discarded
module ether_bus_rx
   import ether_pkg::*;
#(
   parameter int          ADDR_WIDTH   = 16,
   parameter int          DATA_WIDTH   = 16,
   parameter int          MAX_OPS      = 8,
   parameter logic [47:0] FPGA_MAC     = 48'h69_69_5A_06_54_91,
   parameter bit          ACCEPT_BCAST = 1'b1,
   parameter logic [15:0] WRITE_ETYPE  = 16'h0004,
   parameter logic [15:0] READ_ETYPE   = 16'h0002
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  crsdv,
   input  logic [1:0]            rxd,
   output logic [ADDR_WIDTH-1:0] addr_o,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  rw_o,
   output logic                  valid_o,
   output logic                  drop_o
);

   localparam int REC_W     = ADDR_WIDTH + DATA_WIDTH;
   localparam int REC_BYTES = REC_W / 8;
   // One counter serves both the header and the record byte positions.
   localparam int CNT_MAX   = (HEADER_BYTES > REC_BYTES) ? HEADER_BYTES : REC_BYTES;
   localparam int CNT_W     = $clog2(CNT_MAX);

   localparam logic [CNT_W-1:0] DST_LAST = CNT_W'(DST_BYTES - 1);
   localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(HEADER_BYTES - 1);
   localparam logic [CNT_W-1:0] REC_LAST = CNT_W'(REC_BYTES - 1);
   localparam logic [7:0]       MAX_N    = MAX_OPS[7:0];

   state_t r_state;
   state_t w_state_nxt;

   logic             r_quiet;   // set by reset: ignore carrier until it drops
   logic [CNT_W-1:0] r_bcnt;
   logic [39:0]      r_hdr;     // last five header bytes
   logic [REC_W-9:0] r_rec;     // record bytes received so far
   logic [7:0]       r_ops;
   logic             r_rw;

   logic             w_byte_en;
   logic             w_clr;
   logic             w_byte_vld;
   logic [7:0]       w_byte;
   logic [47:0]      w_dst;
   logic [15:0]      w_etype;
   logic [REC_W-1:0] w_rec_nxt;
   logic             w_dst_ok;
   logic             w_etype_ok;
   logic             w_n_ok;
   logic             w_dst_last;
   logic             w_hdr_last;
   logic             w_rec_last;
   logic             w_valid_nxt;
   logic             w_drop_nxt;

   rmii_dibit_deser u_deser (
      .clk        (clk),
      .rst        (rst),
      .i_en       (w_byte_en),
      .i_clr      (w_clr),
      .i_rxd      (rxd),
      .o_byte_vld (w_byte_vld),
      .o_byte_dat (w_byte)
   );

   // Field views that include the byte arriving this cycle.
   assign w_dst      = {r_hdr, w_byte};
   assign w_etype    = {r_hdr[7:0], w_byte};
   assign w_rec_nxt  = {r_rec, w_byte};
   assign w_dst_ok   = (w_dst == FPGA_MAC) || (ACCEPT_BCAST && (w_dst == BCAST_MAC));
   assign w_etype_ok = (w_etype == WRITE_ETYPE) || (w_etype == READ_ETYPE);
   assign w_n_ok     = (w_byte != 8'd0) && (w_byte <= MAX_N);
   assign w_dst_last = (r_bcnt == DST_LAST);
   assign w_hdr_last = (r_bcnt == HDR_LAST);
   assign w_rec_last = (r_bcnt == REC_LAST);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE: begin
            if (crsdv && !r_quiet && (rxd == PREAMBLE_DIBIT)) w_state_nxt = PREAMBLE;
         end
         PREAMBLE: begin
            if (!crsdv)                     w_state_nxt = IDLE;
            else if (rxd == SFD_DIBIT)      w_state_nxt = HEADER;
            else if (rxd != PREAMBLE_DIBIT) w_state_nxt = DRAIN;
         end
         HEADER: begin
            if (!crsdv) begin
               w_state_nxt = IDLE;
            end else if (w_byte_vld) begin
               if (w_dst_last && !w_dst_ok) w_state_nxt = DRAIN;
               else if (w_hdr_last)         w_state_nxt = w_etype_ok ? COUNT : DRAIN;
            end
         end
         COUNT: begin
            if (!crsdv)          w_state_nxt = IDLE;
            else if (w_byte_vld) w_state_nxt = w_n_ok ? RECORD : DRAIN;
         end
         RECORD: begin
            if (!crsdv) w_state_nxt = IDLE;
            else if (w_byte_vld && w_rec_last && (r_ops == 8'd1)) w_state_nxt = DRAIN;
         end
         DRAIN: begin
            if (!crsdv) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Output logic: deserializer control and next-cycle strobes
   always_comb begin
      w_byte_en   = 1'b0;
      w_clr       = 1'b0;
      w_valid_nxt = 1'b0;
      w_drop_nxt  = 1'b0;
      unique case (r_state)
         PREAMBLE: begin
            w_clr      = crsdv && (rxd == SFD_DIBIT);
            w_drop_nxt = crsdv && (rxd != SFD_DIBIT) && (rxd != PREAMBLE_DIBIT);
         end
         HEADER: begin
            w_byte_en  = crsdv;
            w_drop_nxt = !crsdv ||
                         (w_byte_vld && ((w_dst_last && !w_dst_ok) ||
                                         (w_hdr_last && !w_etype_ok)));
         end
         COUNT: begin
            w_byte_en  = crsdv;
            w_drop_nxt = !crsdv || (w_byte_vld && !w_n_ok);
         end
         RECORD: begin
            w_byte_en   = crsdv;
            w_drop_nxt  = !crsdv;
            w_valid_nxt = w_byte_vld && w_rec_last;
         end
         default: ;
      endcase
   end

   // Datapath and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_quiet <= 1'b1;
         r_bcnt  <= '0;
         r_hdr   <= '0;
         r_rec   <= '0;
         r_ops   <= 8'd0;
         r_rw    <= 1'b0;
         addr_o  <= '0;
         data_o  <= '0;
         rw_o    <= 1'b0;
         valid_o <= 1'b0;
         drop_o  <= 1'b0;
      end else begin
         valid_o <= w_valid_nxt;
         drop_o  <= w_drop_nxt;
         if (!crsdv) r_quiet <= 1'b0;

         unique case (r_state)
            PREAMBLE: r_bcnt <= '0;
            HEADER: begin
               if (w_byte_vld) begin
                  r_hdr  <= {r_hdr[31:0], w_byte};
                  r_bcnt <= w_hdr_last ? '0 : r_bcnt + CNT_W'(1);
                  if (w_hdr_last) r_rw <= (w_etype == WRITE_ETYPE);
               end
            end
            COUNT: begin
               if (w_byte_vld) begin
                  r_ops  <= w_byte;
                  r_bcnt <= '0;
               end
            end
            RECORD: begin
               if (w_byte_vld) begin
                  r_rec <= w_rec_nxt[REC_W-9:0];
                  if (w_rec_last) begin
                     r_bcnt <= '0;
                     r_ops  <= r_ops - 8'd1;
                     addr_o <= w_rec_nxt[REC_W-1 -: ADDR_WIDTH];
                     data_o <= w_rec_nxt[DATA_WIDTH-1:0];
                     rw_o   <= r_rw;
                  end else begin
                     r_bcnt <= r_bcnt + CNT_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ether_bus_rx.sv
module tb_ether_bus_rx;

   logic        clk = 1'b0;
   logic        rst;
   logic        crsdv, crsdv_w;
   logic [1:0]  rxd, rxd_w;

   logic [15:0] addr_o, data_o;
   logic        rw_o, valid_o, drop_o;
   logic [31:0] w_addr;
   logic [7:0]  w_data;
   logic        w_rw, w_valid, w_drop;

   always #10 clk = ~clk;

   ether_bus_rx u_dut (
      .clk(clk), .rst(rst), .crsdv(crsdv), .rxd(rxd),
      .addr_o(addr_o), .data_o(data_o), .rw_o(rw_o),
      .valid_o(valid_o), .drop_o(drop_o)
   );

   ether_bus_rx #(.ADDR_WIDTH(32), .DATA_WIDTH(8), .ACCEPT_BCAST(1'b1)) u_wide (
      .clk(clk), .rst(rst), .crsdv(crsdv_w), .rxd(rxd_w),
      .addr_o(w_addr), .data_o(w_data), .rw_o(w_rw),
      .valid_o(w_valid), .drop_o(w_drop)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Strobe monitor (main DUT logs every transaction; wide DUT is counted)
   logic [15:0] v_addr[$];
   logic [15:0] v_data[$];
   logic        v_rw[$];
   int          v_cyc[$];
   int          drop_cnt = 0;
   int          both_cnt = 0;
   int          w_vcnt   = 0;
   int          w_dcnt   = 0;

   always @(negedge clk) begin
      if (valid_o) begin
         v_addr.push_back(addr_o);
         v_data.push_back(data_o);
         v_rw.push_back(rw_o);
         v_cyc.push_back(cyc);
      end
      if (drop_o) drop_cnt++;
      if (valid_o && drop_o) both_cnt++;
      if (w_valid && w_drop) both_cnt++;
      if (w_valid) w_vcnt++;
      if (w_drop) w_dcnt++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Frame construction and transmission
   logic [7:0]  fb[$];
   int          byte_end[$];
   int          tgt    = 0;
   int          rst_at = -1;
   logic [15:0] snap_addr, snap_data;
   logic        snap_rw, snap_valid, snap_drop;

   task automatic drive(input logic c, input logic [1:0] d);
      @(negedge clk);
      if (tgt == 0) begin
         crsdv = c;
         rxd   = d;
      end else begin
         crsdv_w = c;
         rxd_w   = d;
      end
   endtask

   task automatic hdr(input logic [47:0] dst, input logic [15:0] et, input logic [7:0] n);
      fb.delete();
      for (int i = 5; i >= 0; i--) fb.push_back(dst[8*i +: 8]);
      for (int i = 0; i < 6; i++) fb.push_back(8'h10 + 8'(i));
      fb.push_back(et[15:8]);
      fb.push_back(et[7:0]);
      fb.push_back(n);
   endtask

   task automatic rec16(input logic [15:0] a, input logic [15:0] d);
      fb.push_back(a[15:8]);
      fb.push_back(a[7:0]);
      fb.push_back(d[15:8]);
      fb.push_back(d[7:0]);
   endtask

   task automatic clr_mon();
      v_addr.delete();
      v_data.delete();
      v_rw.delete();
      v_cyc.delete();
      drop_cnt = 0;
      w_vcnt   = 0;
      w_dcnt   = 0;
   endtask

   task automatic send_frame();
      logic [7:0] b;
      for (int i = 0; i < 28; i++) drive(1'b1, 2'b01);
      drive(1'b1, 2'b01);
      drive(1'b1, 2'b01);
      drive(1'b1, 2'b01);
      drive(1'b1, 2'b11);
      byte_end.delete();
      for (int i = 0; i < fb.size(); i++) begin
         b = fb[i];
         for (int j = 0; j < 4; j++) begin
            drive(1'b1, b[2*j +: 2]);
            if (i == rst_at && j == 0) rst = 1'b1;
            if (i == rst_at && j == 1) begin
               rst        = 1'b0;
               snap_addr  = addr_o;
               snap_data  = data_o;
               snap_rw    = rw_o;
               snap_valid = valid_o;
               snap_drop  = drop_o;
            end
         end
         byte_end.push_back(cyc);
      end
      for (int k = 0; k < 6; k++) drive(1'b0, 2'b00);
   endtask

   localparam logic [47:0] MAC = 48'h69_69_5A_06_54_91;

   initial begin
      rst = 1'b1; crsdv = 1'b0; rxd = 2'b00; crsdv_w = 1'b0; rxd_w = 2'b00;
      repeat (3) @(negedge clk);
      chk("rst_addr",  addr_o,  16'h0);
      chk("rst_data",  data_o,  16'h0);
      chk("rst_rw",    rw_o,    1'b0);
      chk("rst_valid", valid_o, 1'b0);
      chk("rst_drop",  drop_o,  1'b0);
      chk("rst_waddr", w_addr,  32'h0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Write frame, one record, FCS trailing
      clr_mon();
      hdr(MAC, 16'h0004, 8'd1);
      rec16(16'h0012, 16'hBEEF);
      fb.push_back(8'h11); fb.push_back(8'h22); fb.push_back(8'h33); fb.push_back(8'h44);
      send_frame();
      chk("wr_count", v_addr.size(), 1);
      if (v_addr.size() >= 1) begin
         chk("wr_addr", v_addr[0], 16'h0012);
         chk("wr_data", v_data[0], 16'hBEEF);
         chk("wr_rw",   v_rw[0],   1'b1);
         chk("wr_lat",  v_cyc[0],  byte_end[18] + 1);
      end
      chk("wr_drop", drop_cnt, 0);

      // Read frame, three records, padding and FCS
      clr_mon();
      hdr(MAC, 16'h0002, 8'd3);
      rec16(16'h0001, 16'h0000);
      rec16(16'h0002, 16'h0000);
      rec16(16'h0003, 16'h0000);
      for (int i = 0; i < 50; i++) fb.push_back(8'h00);
      send_frame();
      chk("rd_count", v_addr.size(), 3);
      if (v_addr.size() >= 3) begin
         chk("rd_addr0", v_addr[0], 16'h0001);
         chk("rd_addr1", v_addr[1], 16'h0002);
         chk("rd_addr2", v_addr[2], 16'h0003);
         chk("rd_rw",    {v_rw[0], v_rw[1], v_rw[2]}, 3'b000);
         chk("rd_lat",   v_cyc[0], byte_end[18] + 1);
         chk("rd_gap01", v_cyc[1] - v_cyc[0], 16);
         chk("rd_gap12", v_cyc[2] - v_cyc[1], 16);
      end
      chk("rd_drop", drop_cnt, 0);

      // Wrong destination, then a good frame
      clr_mon();
      hdr(48'h02_00_00_00_00_01, 16'h0004, 8'd1);
      rec16(16'hAAAA, 16'h5555);
      send_frame();
      chk("dst_valid", v_addr.size(), 0);
      chk("dst_drop",  drop_cnt, 1);
      clr_mon();
      hdr(MAC, 16'h0004, 8'd1);
      rec16(16'h1234, 16'h5678);
      send_frame();
      chk("good_count", v_addr.size(), 1);
      if (v_addr.size() >= 1) begin
         chk("good_addr", v_addr[0], 16'h1234);
         chk("good_data", v_data[0], 16'h5678);
      end
      chk("good_drop", drop_cnt, 0);

      // Unknown ethertype
      clr_mon();
      hdr(MAC, 16'h0800, 8'd1);
      rec16(16'h0101, 16'h0202);
      send_frame();
      chk("etype_valid", v_addr.size(), 0);
      chk("etype_drop",  drop_cnt, 1);

      // N = 0
      clr_mon();
      hdr(MAC, 16'h0004, 8'd0);
      rec16(16'h0101, 16'h0202);
      send_frame();
      chk("n0_valid", v_addr.size(), 0);
      chk("n0_drop",  drop_cnt, 1);

      // N = MAX_OPS + 1
      clr_mon();
      hdr(MAC, 16'h0004, 8'd9);
      rec16(16'h0101, 16'h0202);
      send_frame();
      chk("n9_valid", v_addr.size(), 0);
      chk("n9_drop",  drop_cnt, 1);

      // N = MAX_OPS exactly
      clr_mon();
      hdr(MAC, 16'h0004, 8'd8);
      for (int i = 1; i <= 8; i++) rec16(16'(i), 16'(i * 256));
      send_frame();
      chk("n8_count", v_addr.size(), 8);
      if (v_addr.size() >= 8) begin
         chk("n8_addr7", v_addr[7], 16'h0008);
         chk("n8_data7", v_data[7], 16'h0800);
      end
      chk("n8_drop", drop_cnt, 0);

      // Carrier lost in the middle of the second record
      clr_mon();
      hdr(MAC, 16'h0004, 8'd2);
      rec16(16'h0A0A, 16'h0B0B);
      fb.push_back(8'h0C);
      fb.push_back(8'h0C);
      send_frame();
      chk("cut_count", v_addr.size(), 1);
      if (v_addr.size() >= 1) chk("cut_addr", v_addr[0], 16'h0A0A);
      chk("cut_drop",  drop_cnt, 1);
      chk("hold_addr", addr_o, 16'h0A0A);
      chk("hold_data", data_o, 16'h0B0B);

      // Reset in the middle of a record
      clr_mon();
      hdr(MAC, 16'h0004, 8'd1);
      rec16(16'h7777, 16'h8888);
      rst_at = 16;
      send_frame();
      rst_at = -1;
      chk("mrst_addr",  snap_addr,  16'h0);
      chk("mrst_data",  snap_data,  16'h0);
      chk("mrst_rw",    snap_rw,    1'b0);
      chk("mrst_strb",  {snap_valid, snap_drop}, 2'b00);
      chk("mrst_valid", v_addr.size(), 0);
      chk("mrst_drop",  drop_cnt, 0);
      clr_mon();
      hdr(MAC, 16'h0004, 8'd1);
      rec16(16'h4321, 16'h8765);
      send_frame();
      chk("recov_count", v_addr.size(), 1);
      if (v_addr.size() >= 1) chk("recov_addr", v_addr[0], 16'h4321);

      // Wide instance: 32-bit address, 8-bit data, broadcast destination
      clr_mon();
      tgt = 1;
      hdr(48'hFFFF_FFFF_FFFF, 16'h0004, 8'd1);
      fb.push_back(8'hDE); fb.push_back(8'hAD); fb.push_back(8'hBE);
      fb.push_back(8'hEF); fb.push_back(8'h5A);
      send_frame();
      tgt = 0;
      chk("wide_count", w_vcnt, 1);
      chk("wide_addr",  w_addr, 32'hDEADBEEF);
      chk("wide_data",  w_data, 8'h5A);
      chk("wide_rw",    w_rw,   1'b1);
      chk("wide_drop",  w_dcnt, 0);
      chk("main_quiet", v_addr.size(), 0);

      chk("strobe_overlap", both_cnt, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ether_bus_rx.md
Name: ether_bus_rx

Overview:
- Parametrised successor to the single-transaction Ethernet receive bridge: decodes RMII frames directly (preamble/SFD, MAC filter, ethertype) and emits one or more bus transactions per frame.
- Address/data widths, own MAC address and ethertypes are parameters.
- Sits between the RMII PHY pins and the core bus, on the 50 MHz RMII clock.
- No backpressure: the core bus always accepts.

Parameters:
- ADDR_WIDTH, 16, bus address width; multiple of 8, range 8..32.
- DATA_WIDTH, 16, bus data width; multiple of 8, range 8..32.
- MAX_OPS, 8, maximum records per frame, 1..255.
- FPGA_MAC, 48'h69_69_5A_06_54_91, accepted destination MAC.
- ACCEPT_BCAST, 1, also accept destination FF:FF:FF:FF:FF:FF.
- WRITE_ETYPE, 16'h0004, ethertype marking a write frame.
- READ_ETYPE, 16'h0002, ethertype marking a read frame.

Ports:
- clk  in  1  RMII reference clock, 50 MHz.
- rst  in  1  Synchronous reset, active-high.
- crsdv  in  1  RMII carrier-sense/data-valid.
- rxd  in  2  RMII receive dibit.
- addr_o  out  ADDR_WIDTH  Transaction address.
- data_o  out  DATA_WIDTH  Write data; don't-care on reads.
- rw_o  out  1  1 = write, 0 = read.
- valid_o  out  1  One-cycle strobe; addr_o, data_o and rw_o are qualified by it.
- drop_o  out  1  One-cycle strobe when a frame is discarded.

Behaviour:
Clocking and reset:
- Single clock, clk; synchronous active-high reset, rst.
- In reset: all outputs 0, state IDLE, counters 0.
- Reset mid-frame aborts the frame silently: no valid_o, no drop_o. The rest of that frame is ignored until crsdv has been low for 1 cycle.

Dibits and bytes:
- Dibits arrive LSB first: the first dibit of a byte is bits [1:0].
- Multi-byte fields are network order (MSB byte first).
- A frame ends on the first cycle crsdv = 0.

Frame layout after SFD:
- dst MAC (6 B), src MAC (6 B), ethertype (2 B).
- Count byte N.
- N records of ADDR_WIDTH/8 address bytes then DATA_WIDTH/8 data bytes.
- Any trailing bytes (padding, FCS) are ignored.

States:
- IDLE: on crsdv=1 and rxd=01 -> PREAMBLE; otherwise stay.
- PREAMBLE:
  - rxd=01 stay.
  - rxd=11 (SFD tail) -> HEADER with byte and dibit counters cleared.
  - any other dibit -> DRAIN with drop_o.
- HEADER:
  - Collect 14 bytes.
  - At byte 6, dst must equal FPGA_MAC, or broadcast when ACCEPT_BCAST=1; else -> DRAIN with drop_o.
  - At byte 14, ethertype WRITE_ETYPE sets rw=1 and READ_ETYPE sets rw=0, then -> COUNT; anything else -> DRAIN with drop_o.
- COUNT:
  - N=0 or N>MAX_OPS -> DRAIN with drop_o.
  - Otherwise latch N -> RECORD.
- RECORD:
  - Shift bytes into an address/data shift register.
  - On the final dibit of a record: the next cycle asserts valid_o for exactly 1 cycle with the decoded fields; decrement N.
  - N reaching 0 -> DRAIN with no drop_o.
- DRAIN: wait for crsdv=0 -> IDLE.

Frame ending early (crsdv=0 in any non-IDLE state):
- -> IDLE.
- If in HEADER, COUNT or RECORD: drop_o pulses, and a partially received record produces no valid_o.
- Records already emitted stand; transactions are not retracted.

Output timing:
- Latency: valid_o is high exactly 1 cycle after the clk edge that samples the last dibit of a record.
- Output registers hold their values between strobes.
- Back-to-back records give valid_o pulses 4*(ADDR_WIDTH+DATA_WIDTH)/8 cycles apart.

Other rules:
- drop_o and valid_o are never high in the same cycle.
- No CRC check.
- Width counters size to clog2 of the largest field, with no overflow at MAX_OPS=255.

Decomposition:
- Package ether_pkg: state enum, PREAMBLE_DIBIT=2'b01, SFD_DIBIT=2'b11, HEADER_BYTES=14, BCAST_MAC.
- Sub-module rmii_dibit_deser: packs dibits into bytes and emits a one-cycle byte_valid. Its byte counter is cleared on SFD and on rst.
- The parent FSM consumes bytes only.

Test Plan:
- Write frame: dst=FPGA_MAC, etype 0x0004, N=1, rec 0x0012_BEEF -> one valid_o with addr_o=0x0012, data_o=0xBEEF, rw_o=1, 1 cycle after the last dibit; drop_o stays 0.
- Read frame: etype 0x0002, N=3, addrs 0x0001/0x0002/0x0003 -> three valid_o pulses 16 cycles apart, rw_o=0, addresses in order; 46 B padding plus FCS ignored.
- Wrong dst 02:00:00:00:00:01 -> no valid_o; drop_o pulses once; the next good frame decodes normally.
- Unknown etype 0x0800, and a separate N=0 frame -> drop_o each, no valid_o.
- crsdv drops mid second record of N=2 -> first valid_o only, then drop_o; also rst asserted mid-record -> outputs 0, no strobes.
- ADDR_WIDTH=32, DATA_WIDTH=8, ACCEPT_BCAST=1, broadcast dst, rec 0xDEADBEEF_5A -> addr_o=0xDEADBEEF, data_o=0x5A.
